// File: rtl/fp_sweep_pkg.sv
// fp_sweep_pkg: shared types and helpers for the fp activation sweep engine.
//   - sweep_state_e : sweep FSM state encoding (IDLE, RUN, DRAIN, DONE)
//   - tag_entry_t   : in-flight tag layout {mask, codes} at the default
//                     configuration (W=16, LANES=1); the engine declares the
//                     same layout locally at its own parameter values
//   - CRC32_POLY / CRC32_INIT : constants for the optional result signature
//   - popcount()    : set-bit count of a lane mask (up to 64 lanes)
package fp_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sweep_state_e;

    localparam int SWEEP_W_DEF     = 16;
    localparam int SWEEP_LANES_DEF = 1;

    typedef struct packed {
        logic [SWEEP_LANES_DEF-1:0]             mask;
        logic [SWEEP_LANES_DEF*SWEEP_W_DEF-1:0] codes;
    } tag_entry_t;

    localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;

    function automatic logic [6:0] popcount(input logic [63:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            n = n + {6'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/sweep_tag_fifo.sv
// sweep_tag_fifo: synchronous FIFO holding the tags of beats that have been
// issued to the activation unit but whose results have not yet returned.
// Ports:
//   clock, reset (sync, active-high)
//   push, wdata  : write side; accepted when not full, or when full and a pop
//                  happens in the same cycle
//   pop, rdata   : read side; rdata is the current head (show-ahead)
//   full, empty  : occupancy flags
// Same-cycle push and pop are both performed and leave occupancy unchanged.
module sweep_tag_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fp_act_sweep_engine.sv
// fp_act_sweep_engine: exhaustive-sweep driver and result collector for fp
// activation units with valid/ready interfaces.
// Issues codes cfg_first..cfg_last (inclusive, wrapping mod 2^W) across LANES
// lanes, remembers each issued beat in a tag FIFO and pairs it with the next
// returned result beat, so the unit's latency never needs to be known.
// Ports:
//   clock, reset                   : single clock, sync active-high reset
//   start, cfg_first, cfg_last     : sweep launch (honoured in IDLE/DONE)
//   dut_ivalid/iready/datain       : issue side toward the unit
//   dut_ovalid/oready/dataout      : result side from the unit
//   rec_valid/ready/mask/in/out    : (input, output) records to the sink
//   busy, done                     : RUN or DRAIN / DONE
//   err_orphan                     : sticky; a result arrived with no tag
//   retired                        : elements retired in this sweep
//   dbg_state                      : FSM state (fp_sweep_pkg encoding)
//   sig                            : CRC-32 over recorded results, present
//                                    only when FP_SWEEP_SIGNATURE_EN is defined
// Handshake rule on every interface: a transfer happens on a rising clock edge
// where valid and ready are both high; valid, once high, holds its payload
// until that transfer and never depends combinationally on its own ready.
module fp_act_sweep_engine
    import fp_sweep_pkg::*;
#(
    parameter int W            = 16,
    parameter int LANES        = 1,
    parameter int MAX_INFLIGHT = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [W-1:0]       cfg_first,
    input  logic [W-1:0]       cfg_last,
    output logic [LANES-1:0]   dut_ivalid,
    input  logic               dut_iready,
    output logic [LANES*W-1:0] dut_datain,
    input  logic               dut_ovalid,
    output logic               dut_oready,
    input  logic [LANES*W-1:0] dut_dataout,
    output logic               rec_valid,
    input  logic               rec_ready,
    output logic [LANES-1:0]   rec_mask,
    output logic [LANES*W-1:0] rec_in,
    output logic [LANES*W-1:0] rec_out,
    output logic               busy,
    output logic               done,
    output logic               err_orphan,
    output logic [W:0]         retired,
`ifdef FP_SWEEP_SIGNATURE_EN
    output logic [31:0]        sig,
`endif
    output logic [1:0]         dbg_state
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_RUN   = ST_RUN;
    localparam logic [1:0] S_DRAIN = ST_DRAIN;
    localparam logic [1:0] S_DONE  = ST_DONE;

    typedef struct packed {
        logic [LANES-1:0]   mask;
        logic [LANES*W-1:0] codes;
    } entry_t;

    logic [1:0]   state;
    logic [W-1:0] base;
    logic [W:0]   remaining;
    logic [W:0]   n_codes;
    logic [W:0]   issue_cnt;
    logic [W:0]   remaining_next;
    logic         start_ok;
    logic         xfer;
    logic         take;
    logic         pop;
    logic         orphan;
    logic         fifo_full;
    logic         fifo_empty;
    entry_t       push_entry;
    entry_t       head_entry;

    assign dbg_state = state;
    assign busy      = (state == S_RUN) || (state == S_DRAIN);
    assign done      = (state == S_DONE);
    assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));

    // N = ((last - first) mod 2^W) + 1; needs W+1 bits for the full 2^W sweep.
    assign n_codes = {1'b0, cfg_last - cfg_first} + (W+1)'(1);

    // Lanes beyond the remaining count go quiet on the final partial beat.
    // Payload is zeroed outside RUN so idle outputs read as 0.
    always_comb begin
        dut_ivalid = '0;
        dut_datain = '0;
        for (int i = 0; i < LANES; i++) begin
            dut_ivalid[i] = (state == S_RUN) && ((W+1)'(i) < remaining) && !fifo_full;
            if (state == S_RUN) dut_datain[i*W +: W] = base + W'(i);
        end
    end

    assign xfer           = (|dut_ivalid) && dut_iready;
    assign issue_cnt      = (W+1)'(popcount(64'(dut_ivalid)));
    assign remaining_next = remaining - issue_cnt;
    assign push_entry     = '{mask: dut_ivalid, codes: dut_datain};

    // A result is accepted whenever the record slot is free or draining.
    assign dut_oready = (!rec_valid || rec_ready) && busy;
    assign take       = dut_ovalid && dut_oready;
    assign pop        = take && !fifo_empty;
    assign orphan     = take && fifo_empty;

    sweep_tag_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .clock (clock),
        .reset (reset),
        .push  (xfer),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            base       <= '0;
            remaining  <= '0;
            retired    <= '0;
            err_orphan <= 1'b0;
            rec_valid  <= 1'b0;
            rec_mask   <= '0;
            rec_in     <= '0;
            rec_out    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_RUN;
                        base       <= cfg_first;
                        remaining  <= n_codes;
                        retired    <= '0;
                        err_orphan <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (xfer) begin
                        base      <= base + W'(LANES);
                        remaining <= remaining_next;
                        if (remaining_next == '0) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (fifo_empty && !rec_valid) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase

            if (orphan) err_orphan <= 1'b1;

            // A new record may load in the same cycle the old one leaves.
            if (pop) begin
                rec_valid <= 1'b1;
                rec_mask  <= head_entry.mask;
                rec_in    <= head_entry.codes;
                rec_out   <= dut_dataout;
                retired   <= retired + (W+1)'(popcount(64'(head_entry.mask)));
            end else if (rec_ready) begin
                rec_valid <= 1'b0;
            end
        end
    end

`ifdef FP_SWEEP_SIGNATURE_EN
    // MSB-first CRC-32 over each valid lane of a record, lane 0 first.
    function automatic logic [31:0] crc_fold(input logic [31:0]        c,
                                             input logic [LANES-1:0]   m,
                                             input logic [LANES*W-1:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int l = 0; l < LANES; l++) begin
            if (m[l]) begin
                for (int b = W - 1; b >= 0; b--) begin
                    fb = r[31] ^ d[l*W + b];
                    r  = {r[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0);
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            sig <= '0;
        end else if (start_ok) begin
            sig <= CRC32_INIT;
        end else if (rec_valid && rec_ready && (state != S_DONE)) begin
            sig <= crc_fold(sig, rec_mask, rec_out);
        end
    end
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_fp_act_sweep_engine.sv
// tb_fp_act_sweep_engine: directed bench for fp_act_sweep_engine.
// Instance A: W=8, LANES=1, MAX_INFLIGHT=4, driven by a small variable-latency
// unit model (result = code ^ 8'h5A). Instance B: W=16, LANES=4,
// MAX_INFLIGHT=4, driven by hand.
module tb_fp_act_sweep_engine;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // ---------------- instance A (W=8, LANES=1) ----------------
    logic       a_start = 0;
    logic [7:0] a_cfg_first = 0, a_cfg_last = 0;
    logic [0:0] a_ivalid;
    logic       a_iready = 0;
    logic [7:0] a_datain;
    logic       a_ovalid = 0;
    logic       a_oready;
    logic [7:0] a_dataout = 0;
    logic       a_rec_valid;
    logic       a_rec_ready = 0;
    logic [0:0] a_rec_mask;
    logic [7:0] a_rec_in, a_rec_out;
    logic       a_busy, a_done, a_err;
    logic [8:0] a_retired;
    logic [1:0] a_dbg_state;

    fp_act_sweep_engine #(.W(8), .LANES(1), .MAX_INFLIGHT(4)) u_dut_a (
        .clock(clock), .reset(reset), .start(a_start),
        .cfg_first(a_cfg_first), .cfg_last(a_cfg_last),
        .dut_ivalid(a_ivalid), .dut_iready(a_iready), .dut_datain(a_datain),
        .dut_ovalid(a_ovalid), .dut_oready(a_oready), .dut_dataout(a_dataout),
        .rec_valid(a_rec_valid), .rec_ready(a_rec_ready), .rec_mask(a_rec_mask),
        .rec_in(a_rec_in), .rec_out(a_rec_out),
        .busy(a_busy), .done(a_done), .err_orphan(a_err), .retired(a_retired),
        .dbg_state(a_dbg_state)
    );

    // ---------------- instance B (W=16, LANES=4) ----------------
    logic        b_start = 0;
    logic [15:0] b_cfg_first = 0, b_cfg_last = 0;
    logic [3:0]  b_ivalid;
    logic        b_iready = 0;
    logic [63:0] b_datain;
    logic        b_ovalid = 0;
    logic        b_oready;
    logic [63:0] b_dataout = 0;
    logic        b_rec_valid;
    logic        b_rec_ready = 0;
    logic [3:0]  b_rec_mask;
    logic [63:0] b_rec_in, b_rec_out;
    logic        b_busy, b_done, b_err;
    logic [16:0] b_retired;
    logic [1:0]  b_dbg_state;

    fp_act_sweep_engine #(.W(16), .LANES(4), .MAX_INFLIGHT(4)) u_dut_b (
        .clock(clock), .reset(reset), .start(b_start),
        .cfg_first(b_cfg_first), .cfg_last(b_cfg_last),
        .dut_ivalid(b_ivalid), .dut_iready(b_iready), .dut_datain(b_datain),
        .dut_ovalid(b_ovalid), .dut_oready(b_oready), .dut_dataout(b_dataout),
        .rec_valid(b_rec_valid), .rec_ready(b_rec_ready), .rec_mask(b_rec_mask),
        .rec_in(b_rec_in), .rec_out(b_rec_out),
        .busy(b_busy), .done(b_done), .err_orphan(b_err), .retired(b_retired),
        .dbg_state(b_dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Unit model and scoreboard for instance A.
    bit         model_on  = 0;
    bit         rr_toggle = 0;
    int         lat       = 5;
    logic [7:0] pipe_code[$];
    int         pipe_t[$];
    logic [7:0] exp_q[$];
    logic [7:0] nxt_issue = 0;
    int         issued = 0;
    int         popped = 0;
    int         recs   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic load_exp(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(first + 8'(i));
        nxt_issue = first;
        recs      = 0;
    endtask

    task automatic model_drive();
        a_iready = 1'b1;
        if (pipe_code.size() != 0 && pipe_t[0] <= cyc) begin
            a_ovalid  = 1'b1;
            a_dataout = pipe_code[0] ^ 8'h5A;
        end else begin
            a_ovalid  = 1'b0;
            a_dataout = 8'h00;
        end
        a_rec_ready = rr_toggle ? cyc[0] : 1'b1;
    endtask

    // Evaluates the handshakes that the coming rising edge will perform.
    task automatic model_check();
        logic [7:0] e;
        if (a_ovalid && a_oready) begin
            void'(pipe_code.pop_front());
            void'(pipe_t.pop_front());
            popped++;
        end
        if (a_ivalid[0] && a_iready) begin
            chk("issue_code", a_datain, nxt_issue);
            nxt_issue = nxt_issue + 8'd1;
            pipe_code.push_back(a_datain);
            pipe_t.push_back(cyc + lat);
            issued++;
        end
        chk("inflight_bound", ((issued - popped) <= 4), 1);
        if (a_rec_valid && a_rec_ready) begin
            chk("rec_q_nonempty", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rec_in", a_rec_in, e);
                chk("rec_out", a_rec_out, e ^ 8'h5A);
                chk("rec_mask", a_rec_mask, 1);
            end
            recs++;
        end
    endtask

    // One clock: inputs change on the falling edge, outputs are read 1 unit later.
    task automatic tick();
        @(negedge clock);
        cyc++;
        if (model_on) model_drive();
        #1;
        if (model_on) model_check();
    endtask

    task automatic wait_done_a(input int lim);
        for (int i = 0; i < lim && !a_done; i++) tick();
        chk("a_done_reached", a_done, 1);
    endtask

    task automatic wait_done_b(input int lim);
        for (int i = 0; i < lim && !b_done; i++) tick();
        chk("b_done_reached", b_done, 1);
    endtask

    task automatic start_a(input logic [7:0] f, input logic [7:0] l);
        a_cfg_first = f;
        a_cfg_last  = l;
        a_start     = 1'b1;
        tick();
        a_start     = 1'b0;
    endtask

    initial begin
        // ---------------- reset ----------------
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_a_state", a_dbg_state, 0);
        chk("rst_a_ivalid", a_ivalid, 0);
        chk("rst_a_oready", a_oready, 0);
        chk("rst_a_rec_valid", a_rec_valid, 0);
        chk("rst_a_busy_done", {a_busy, a_done, a_err}, 0);
        chk("rst_a_retired", a_retired, 0);
        chk("rst_b_outputs", {b_ivalid, b_oready, b_rec_valid, b_busy, b_done, b_err}, 0);
        chk("rst_b_datain", b_datain, 0);

        // ---------------- B: single code 0x3C00 ----------------
        b_cfg_first = 16'h3C00;
        b_cfg_last  = 16'h3C00;
        b_start     = 1'b1;
        tick();
        b_start = 1'b0;
        chk("b1_ivalid", b_ivalid, 4'b0001);
        chk("b1_datain", b_datain[15:0], 16'h3C00);
        chk("b1_busy", b_busy, 1);
        b_iready = 1'b1;
        tick();
        b_iready = 1'b0;
        chk("b1_ivalid_after", b_ivalid, 0);
        chk("b1_state_drain", b_dbg_state, 2);
        b_ovalid    = 1'b1;
        b_dataout   = 64'h0000_0000_0000_ABCD;
        b_rec_ready = 1'b0;
        tick();
        b_ovalid = 1'b0;
        chk("b1_rec_valid", b_rec_valid, 1);
        chk("b1_rec_mask", b_rec_mask, 4'b0001);
        chk("b1_rec_in", b_rec_in[15:0], 16'h3C00);
        chk("b1_rec_out", b_rec_out[15:0], 16'hABCD);
        chk("b1_retired", b_retired, 1);
        tick();
        chk("b1_rec_held", b_rec_valid, 1);
        b_rec_ready = 1'b1;
        wait_done_b(10);
        chk("b1_rec_cleared", b_rec_valid, 0);
        chk("b1_done_retired", b_retired, 1);

        // ---------------- B: wrapping 4-lane sweep FFFE..0003 ----------------
        b_cfg_first = 16'hFFFE;
        b_cfg_last  = 16'h0003;
        b_start     = 1'b1;
        tick();
        b_start = 1'b0;
        chk("b2_beat0_ivalid", b_ivalid, 4'b1111);
        chk("b2_beat0_datain", b_datain, 64'h0001_0000_FFFF_FFFE);
        chk("b2_retired_cleared", b_retired, 0);
        b_iready = 1'b1;
        tick();
        chk("b2_beat1_ivalid", b_ivalid, 4'b0011);
        chk("b2_beat1_datain", b_datain[31:0], 32'h0003_0002);
        tick();
        b_iready = 1'b0;
        chk("b2_issue_over", b_ivalid, 0);
        b_ovalid  = 1'b1;
        b_dataout = 64'h1111_2222_3333_4444;
        tick();
        chk("b2_rec0_mask", b_rec_mask, 4'b1111);
        chk("b2_rec0_in", b_rec_in, 64'h0001_0000_FFFF_FFFE);
        chk("b2_rec0_out", b_rec_out, 64'h1111_2222_3333_4444);
        chk("b2_rec0_retired", b_retired, 4);
        b_dataout = 64'h5555_6666_7777_8888;
        tick();
        b_ovalid = 1'b0;
        chk("b2_rec1_mask", b_rec_mask, 4'b0011);
        chk("b2_rec1_in", b_rec_in[31:0], 32'h0003_0002);
        chk("b2_rec1_out", b_rec_out[31:0], 32'h7777_8888);
        chk("b2_rec1_retired", b_retired, 6);
        wait_done_b(10);
        chk("b2_err", b_err, 0);

        // ---------------- A: orphan result, then finish sweep ----------------
        a_iready = 1'b0;
        start_a(8'h10, 8'h12);
        chk("a_first_ivalid", a_ivalid, 1);
        chk("a_first_datain", a_datain, 8'h10);
        chk("a_oready_run", a_oready, 1);
        tick();
        chk("a_hold_ivalid", a_ivalid, 1);
        chk("a_hold_datain", a_datain, 8'h10);
        a_ovalid  = 1'b1;
        a_dataout = 8'h77;
        tick();
        a_ovalid = 1'b0;
        chk("orphan_set", a_err, 1);
        chk("orphan_no_rec", a_rec_valid, 0);
        chk("orphan_retired", a_retired, 0);
        tick();
        chk("orphan_sticky", a_err, 1);
        lat = 5;
        rr_toggle = 1'b0;
        load_exp(8'h10, 3);
        model_on = 1'b1;
        wait_done_a(200);
        chk("orphan_sweep_recs", recs, 3);
        chk("orphan_sweep_retired", a_retired, 3);
        chk("orphan_sweep_q", exp_q.size(), 0);
        chk("orphan_sticky_done", a_err, 1);

        // ---------------- A: full 2^8 sweep, latency 5 ----------------
        load_exp(8'h00, 256);
        start_a(8'h00, 8'hFF);
        chk("full_err_cleared", a_err, 0);
        wait_done_a(3000);
        chk("full_recs", recs, 256);
        chk("full_retired", a_retired, 9'h100);
        chk("full_q", exp_q.size(), 0);
        chk("full_err", a_err, 0);

        // ---------------- A: backpressure, latency 7, wrap F0..0F ----------------
        lat = 7;
        rr_toggle = 1'b1;
        load_exp(8'hF0, 32);
        start_a(8'hF0, 8'h0F);
        repeat (3) tick();
        start_a(8'h80, 8'h81);  // ignored while running
        wait_done_a(2000);
        chk("bp_recs", recs, 32);
        chk("bp_retired", a_retired, 32);
        chk("bp_q", exp_q.size(), 0);

        // ---------------- A: reset at beat 100 ----------------
        lat = 5;
        rr_toggle = 1'b0;
        issued = 0;
        popped = 0;
        load_exp(8'h00, 256);
        start_a(8'h00, 8'hFF);
        for (int i = 0; i < 2000 && issued < 100; i++) tick();
        chk("reach_beat100", issued, 100);
        model_on    = 1'b0;
        a_iready    = 1'b0;
        a_ovalid    = 1'b0;
        a_rec_ready = 1'b0;
        reset       = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_state", a_dbg_state, 0);
        chk("midrst_ivalid", a_ivalid, 0);
        chk("midrst_rec_valid", a_rec_valid, 0);
        chk("midrst_busy", a_busy, 0);
        chk("midrst_retired", a_retired, 0);
        pipe_code.delete();
        pipe_t.delete();
        exp_q.delete();
        issued = 0;
        popped = 0;
        load_exp(8'h20, 16);
        model_on = 1'b1;
        start_a(8'h20, 8'h2F);
        wait_done_a(500);
        chk("post_recs", recs, 16);
        chk("post_retired", a_retired, 16);
        chk("post_q", exp_q.size(), 0);
        chk("post_err", a_err, 0);

        model_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
